point_step_arbiter: RTL

POINT_STEP_ARBITER -- requirements
Module: point_step_arbiter

---
 rtl/point_pkg.sv | 38 +++
 rtl/point_rr_arb.sv | 38 +++
 rtl/point_step_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/point_pkg.sv
// Shared types and helpers for the two-requester point-step arbiter.
package point_pkg;

    // Point operand/result: two independent unsigned 8-bit coordinates.
    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
    } t_point;

    // Step direction applied to both coordinates.
    typedef enum logic {
        OP_INC = 1'b0,
        OP_DEC = 1'b1
    } t_op;

    // Requester identifiers as carried on res_id and held in last_grant.
    localparam logic ID_A = 1'b0;
    localparam logic ID_B = 1'b1;

    // Apply a step to both coordinates; each field wraps modulo 256.
    function automatic t_point apply_step(input t_point p, input t_op op, input logic [7:0] step);
        t_point r;
        if (op == OP_INC) begin
            r.x = p.x + step;
            r.y = p.y + step;
        end else begin
            r.x = p.x - step;
            r.y = p.y - step;
        end
        return r;
    endfunction

    // Saturating 8-bit increment used by the grant counters.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/point_rr_arb.sv
// Two-way round-robin arbiter; remembers the last accepted requester.
module point_rr_arb
    import point_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic adv_i,
    input  logic valid_a_i,
    input  logic valid_b_i,
    output logic grant_a_o,
    output logic grant_b_o
);

    logic last_grant_q;
    logic last_grant_d;

    // A wins when alone, or under contention if B was granted last.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no latch is inferred.
        grant_a_o    = valid_a_i & (~valid_b_i | (last_grant_q == ID_B));
        grant_b_o    = valid_b_i & ~grant_a_o;
        last_grant_d = last_grant_q;
        if (adv_i && (grant_a_o || grant_b_o)) begin
            last_grant_d = grant_b_o ? ID_B : ID_A;
        end
    end

    // Priority pointer moves only when a request is actually accepted.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst) begin
            last_grant_q <= ID_B;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/point_step_arbiter.sv
// Shares one point-update datapath between requesters A and B behind a
// one-entry result register with full back-to-back throughput.
module point_step_arbiter
    import point_pkg::*;
#(
    parameter int STEP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_A,
    output logic              req_ready_A,
    input  t_point            req_point_A,
    input  t_op               req_op_A,
    input  logic [STEP_W-1:0] req_step_A,
    input  logic              req_valid_B,
    output logic              req_ready_B,
    input  t_point            req_point_B,
    input  t_op               req_op_B,
    input  logic [STEP_W-1:0] req_step_B,
    output logic              res_valid,
    input  logic              res_ready,
    output t_point            res_point,
    output logic              res_id,
    output logic [7:0]        grant_cnt_A,
    output logic [7:0]        grant_cnt_B
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } t_state;

    t_state            state_q;
    logic              res_valid_q;
    t_point            res_point_q;
    t_point            point_d;
    logic              res_id_q;
    logic              id_d;
    logic [7:0]        cnt_a_q;
    logic [7:0]        cnt_b_q;
    logic              adv;
    logic              grant_a;
    logic              grant_b;
    logic              accept;
    t_point            sel_point;
    t_op               sel_op;
    logic [STEP_W-1:0] sel_step;

    // The result slot can take a new entry when empty or being drained;
    // gating with rst keeps both readies low throughout reset.
    assign adv = rst & (~res_valid_q | res_ready);

    point_rr_arb u_arb (
        .clk       (clk),
        .rst       (rst),
        .adv_i     (adv),
        .valid_a_i (req_valid_A),
        .valid_b_i (req_valid_B),
        .grant_a_o (grant_a),
        .grant_b_o (grant_b)
    );

    assign req_ready_A = adv & grant_a;
    assign req_ready_B = adv & grant_b;
    assign accept      = req_ready_A | req_ready_B;

    // Steer the granted requester's operands into the shared datapath.
    always_comb begin
        sel_point = req_point_A;
        sel_op    = req_op_A;
        sel_step  = req_step_A;
        id_d      = ID_A;
        if (grant_b) begin
            sel_point = req_point_B;
            sel_op    = req_op_B;
            sel_step  = req_step_B;
            id_d      = ID_B;
        end
        point_d = apply_step(sel_point, sel_op, 8'(sel_step));
    end

    // EMPTY/FULL result FSM with registered outputs and grant counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_EMPTY;
            res_valid_q <= 1'b0;
            res_point_q <= '{x: 8'h00, y: 8'h00};
            res_id_q    <= ID_A;
            cnt_a_q     <= 8'h00;
            cnt_b_q     <= 8'h00;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_q     <= ST_FULL;
                        res_valid_q <= 1'b1;
                        res_point_q <= point_d;
                        res_id_q    <= id_d;
                    end
                end
                ST_FULL: begin
                    if (accept) begin
                        // Old result drains while the new one loads: no bubble.
                        res_point_q <= point_d;
                        res_id_q    <= id_d;
                    end else if (res_ready) begin
                        state_q     <= ST_EMPTY;
                        res_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_EMPTY;
                    res_valid_q <= 1'b0;
                end
            endcase
            if (req_ready_A) begin
                cnt_a_q <= sat_inc(cnt_a_q);
            end
            if (req_ready_B) begin
                cnt_b_q <= sat_inc(cnt_b_q);
            end
        end
    end

    assign res_valid   = res_valid_q;
    assign res_point   = res_point_q;
    assign res_id      = res_id_q;
    assign grant_cnt_A = cnt_a_q;
    assign grant_cnt_B = cnt_b_q;

endmodule
